// File: rtl/axi_dma_rd_a.sv
`default_nettype none
// ============================================================================
// Module   : axi_dma_rd_a
// Purpose  : Aligned CDMA read engine. It splits (addr, len) commands into INCR
//            AR bursts and passes R beats straight through to AXI4-Stream.
// Revision : 1.0
// ============================================================================
module axi_dma_rd_a #(
    parameter int BURST_LEN       = 16,
    parameter int DATA_BITS       = 256,
    parameter int ADDR_BITS       = 64,
    parameter int ID_BITS         = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int LEN_BITS        = 32
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   ctrl_valid,
    output logic                   stat_ready,
    input  logic [ADDR_BITS-1:0]   ctrl_addr,
    input  logic [LEN_BITS-1:0]    ctrl_len,
    input  logic                   ctrl_ctl,
    output logic                   stat_done,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_BITS-1:0]   araddr,
    output logic [ID_BITS-1:0]     arid,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,
    output logic                   arlock,
    output logic [3:0]             arcache,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [DATA_BITS-1:0]   rdata,
    input  logic [ID_BITS-1:0]     rid,
    input  logic [1:0]             rresp,
    input  logic                   rlast,
    output logic                   axis_out_tvalid,
    input  logic                   axis_out_tready,
    output logic [DATA_BITS-1:0]   axis_out_tdata,
    output logic [DATA_BITS/8-1:0] axis_out_tkeep,
    output logic                   axis_out_tlast
);
    localparam int BYTES    = DATA_BITS / 8;
    localparam int SIZE_LOG = $clog2(BYTES);
    localparam int BL_LOG   = $clog2(BURST_LEN);
    localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    localparam logic [ADDR_BITS-1:0] c_BURST_BYTES = ADDR_BITS'(BURST_LEN * BYTES);
    localparam logic [7:0]           c_FULL_ARLEN  = 8'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]     c_MAX_OUT     = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0]     c_PTR_LAST    = PTR_W'(MAX_OUTSTANDING - 1);
    localparam logic [LEN_BITS-1:0]  c_ONE         = LEN_BITS'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_ISSUE = 2'd2;

    logic [1:0]           r_state;
    logic [LEN_BITS-1:0]  r_beats;
    logic                 r_ctl;
    logic [LEN_BITS-1:0]  r_left;
    logic [BL_LOG-1:0]    r_rem;
    logic                 r_arvalid;
    logic [ADDR_BITS-1:0] r_araddr;
    logic [7:0]           r_arlen;
    logic [CNT_W-1:0]     r_count;
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [1:0]           r_tag_mem [MAX_OUTSTANDING];

    logic                 w_accept;
    logic [LEN_BITS-1:0]  w_full;
    logic [BL_LOG-1:0]    w_rem;
    logic [LEN_BITS-1:0]  w_nbursts;
    logic                 w_ar_hs;
    logic                 w_r_pop;
    logic                 w_tag_ok;
    logic                 w_room;
    logic                 w_final;
    logic [1:0]           w_tag;
    logic                 w_unused_ok;

    assign w_accept  = ctrl_valid & (r_state == c_IDLE);
    assign w_full    = r_beats >> BL_LOG;
    assign w_rem     = r_beats[BL_LOG-1:0];
    assign w_nbursts = w_full + LEN_BITS'(w_rem != '0);
    assign w_ar_hs   = r_arvalid & arready;
    assign w_room    = r_count < c_MAX_OUT;
    assign w_final   = (r_left == c_ONE);
    // The outstanding counter doubles as tag-queue occupancy; an rlast with an
    // empty queue (stray beat after reset) is neither popped nor tagged.
    assign w_tag_ok  = (r_count != '0);
    assign w_r_pop   = rvalid & axis_out_tready & rlast & w_tag_ok;
    assign w_tag     = r_tag_mem[r_rptr];

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_beats   <= '0;
            r_ctl     <= 1'b0;
            r_left    <= '0;
            r_rem     <= '0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_arlen   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_araddr <= ctrl_addr;
                        r_beats  <= ctrl_len >> SIZE_LOG;
                        r_ctl    <= ctrl_ctl;
                        r_state  <= c_LOAD;
                    end
                end
                c_LOAD: begin
                    r_left <= w_nbursts;
                    r_rem  <= w_rem;
                    if (w_nbursts == '0) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_state <= c_ISSUE;
                        // First AR goes out together with the counter load.
                        if (w_room) begin
                            r_arvalid <= 1'b1;
                            r_arlen   <= ((w_nbursts == c_ONE) && (w_rem != '0)) ?
                                         8'(w_rem) - 8'd1 : c_FULL_ARLEN;
                        end
                    end
                end
                c_ISSUE: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_left    <= r_left - c_ONE;
                        r_araddr  <= r_araddr + c_BURST_BYTES;
                        if (w_final) begin
                            r_state <= c_IDLE;
                        end
                    end else if (!r_arvalid && w_room) begin
                        r_arvalid <= 1'b1;
                        r_arlen   <= (w_final && (r_rem != '0)) ? 8'(r_rem) - 8'd1 : c_FULL_ARLEN;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_wptr <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + PTR_W'(1);
            end
            if (w_r_pop) begin
                r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + PTR_W'(1);
            end
            case ({w_ar_hs, w_r_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read while occupancy > 0.
    always_ff @(posedge aclk) begin
        if (w_ar_hs) begin
            r_tag_mem[r_wptr] <= {w_final, r_ctl & w_final};
        end
    end

    assign stat_ready      = (r_state == c_IDLE);
    assign arvalid         = r_arvalid;
    assign araddr          = r_araddr;
    assign arlen           = r_arlen;
    assign arid            = '0;
    assign arsize          = 3'(SIZE_LOG);
    assign arburst         = 2'b01;
    assign arlock          = 1'b0;
    assign arcache         = 4'b0011;

    assign axis_out_tvalid = rvalid;
    assign rready          = axis_out_tready;
    assign axis_out_tdata  = rdata;
    assign axis_out_tkeep  = '1;
    assign axis_out_tlast  = rlast & w_tag_ok & w_tag[1];
    assign stat_done       = rvalid & axis_out_tready & rlast & w_tag_ok & w_tag[0];

    assign w_unused_ok = &{1'b0, rid, rresp, ctrl_len[SIZE_LOG-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axi_dma_rd_a.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_dma_rd_a
// Purpose  : Directed scoreboard bench for axi_dma_rd_a with a memory-model slave.
// Revision : 1.0
// ============================================================================
module tb_axi_dma_rd_a;
    localparam int DB = 256;
    localparam int AB = 64;
    localparam int LB = 32;
    localparam int BL = 16;
    localparam int MO = 2;

    logic           aclk = 1'b0;
    logic           reset = 1'b1;
    logic           ctrl_valid = 1'b0;
    logic           stat_ready;
    logic [AB-1:0]  ctrl_addr = '0;
    logic [LB-1:0]  ctrl_len = '0;
    logic           ctrl_ctl = 1'b0;
    logic           stat_done;
    logic           arvalid;
    logic           arready = 1'b0;
    logic [AB-1:0]  araddr;
    logic [1:0]     arid;
    logic [7:0]     arlen;
    logic [2:0]     arsize;
    logic [1:0]     arburst;
    logic           arlock;
    logic [3:0]     arcache;
    logic           rvalid = 1'b0;
    logic           rready;
    logic [DB-1:0]  rdata = '0;
    logic [1:0]     rid = '0;
    logic [1:0]     rresp = '0;
    logic           rlast = 1'b0;
    logic           axis_out_tvalid;
    logic           axis_out_tready = 1'b1;
    logic [DB-1:0]  axis_out_tdata;
    logic [DB/8-1:0] axis_out_tkeep;
    logic           axis_out_tlast;

    axi_dma_rd_a #(
        .BURST_LEN(BL), .DATA_BITS(DB), .ADDR_BITS(AB),
        .ID_BITS(2), .MAX_OUTSTANDING(MO), .LEN_BITS(LB)
    ) dut (
        .aclk(aclk), .reset(reset),
        .ctrl_valid(ctrl_valid), .stat_ready(stat_ready), .ctrl_addr(ctrl_addr),
        .ctrl_len(ctrl_len), .ctrl_ctl(ctrl_ctl), .stat_done(stat_done),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .rid(rid), .rresp(rresp), .rlast(rlast),
        .axis_out_tvalid(axis_out_tvalid), .axis_out_tready(axis_out_tready),
        .axis_out_tdata(axis_out_tdata), .axis_out_tkeep(axis_out_tkeep),
        .axis_out_tlast(axis_out_tlast)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [DB-1:0] d; logic last; logic done; } beat_t;
    typedef struct { logic [AB-1:0] a; logic [7:0] len; } ar_t;

    beat_t exp_beat_q[$];
    ar_t   exp_ar_q[$];
    ar_t   slv_ar_q[$];

    int errors = 0, checks = 0, cyc = 0;
    int ar_seen = 0, tlast_seen = 0, done_seen = 0, beats_seen = 0, out_cnt = 0;
    int arv_rise_edge = 0, rdy_rise_edge = 0, last_ar_edge = 0, acc_edge = 0, acc_beats = 0;
    int r_started = 0, r_limit = 1000000;
    bit bp = 1'b0;
    bit cur_active = 1'b0;
    logic [AB-1:0] cur_addr = '0;
    int cur_len = 0, cur_beat = 0;
    bit prev_arv = 1'b0, prev_rdy = 1'b1, prev_ar_hs = 1'b0;

    function automatic logic [DB-1:0] mem_data(input logic [AB-1:0] a);
        return {a ^ 64'hDEADBEEF_0BADF00D, ~a, a + 64'h1234, a};
    endfunction

    task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit idle();
        return stat_ready && exp_ar_q.size() == 0 && exp_beat_q.size() == 0 &&
               !cur_active && slv_ar_q.size() == 0;
    endfunction

    always @(posedge aclk) cyc <= cyc + 1;

    // AXI slave backed by a fixed memory pattern, plus stream-side scoreboard.
    always @(negedge aclk) begin
        ar_t t;
        beat_t e;
        ar_t ea;
        if (reset) begin
            rvalid = 1'b0;
            rlast = 1'b0;
            arready = 1'b0;
            axis_out_tready = 1'b1;
            cur_active = 1'b0;
            slv_ar_q.delete();
            exp_ar_q.delete();
            exp_beat_q.delete();
            out_cnt = 0;
            r_started = 0;
            prev_arv = 1'b0;
            prev_rdy = 1'b1;
            prev_ar_hs = 1'b0;
        end else begin
            arready = ($urandom_range(0, 3) != 0);
            axis_out_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!cur_active && slv_ar_q.size() > 0 && r_started < r_limit) begin
                t = slv_ar_q.pop_front();
                cur_active = 1'b1;
                cur_addr = t.a;
                cur_len = int'(t.len);
                cur_beat = 0;
                r_started++;
            end
            rvalid = cur_active;
            rlast = cur_active && (cur_beat == cur_len);
            rdata = mem_data(cur_addr + 64'(cur_beat) * 64'd32);
            #1;
            if (arvalid && !prev_arv) arv_rise_edge = cyc;
            if (stat_ready && !prev_rdy) rdy_rise_edge = cyc;
            prev_arv = arvalid;
            prev_rdy = stat_ready;
            if (prev_ar_hs) check("ar_gap", arvalid, 1'b0);
            check("rready_eq_tready", rready, axis_out_tready);
            check("tvalid_eq_rvalid", axis_out_tvalid, rvalid);
            prev_ar_hs = arvalid && arready;
            if (arvalid && arready) begin
                check("outstanding_cap", out_cnt < MO, 1'b1);
                check("ar_expected", exp_ar_q.size() != 0, 1'b1);
                if (exp_ar_q.size() != 0) begin
                    ea = exp_ar_q.pop_front();
                    check("araddr", araddr, ea.a);
                    check("arlen", arlen, ea.len);
                end
                check("ar_attrs", {arid, arsize, arburst, arlock, arcache},
                      {2'b00, 3'd5, 2'b01, 1'b0, 4'b0011});
                slv_ar_q.push_back('{a: araddr, len: arlen});
                ar_seen++;
                out_cnt++;
                last_ar_edge = cyc + 1;
            end
            if (rvalid && rready) begin
                check("beat_expected", exp_beat_q.size() != 0, 1'b1);
                if (exp_beat_q.size() != 0) begin
                    e = exp_beat_q.pop_front();
                    check("tdata", axis_out_tdata, e.d);
                    check("tlast", axis_out_tlast, e.last);
                    check("stat_done", stat_done, e.done);
                end
                check("tkeep", axis_out_tkeep, {(DB/8){1'b1}});
                beats_seen++;
                if (axis_out_tlast) tlast_seen++;
                if (stat_done) done_seen++;
                if (rlast) begin
                    cur_active = 1'b0;
                    out_cnt--;
                end else begin
                    cur_beat++;
                end
            end else begin
                check("done_idle", stat_done, 1'b0);
            end
        end
    end

    task automatic send_cmd(input logic [AB-1:0] a, input logic [LB-1:0] l, input logic c);
        int n;
        int beats;
        int nb;
        int rem;
        n = 0;
        @(negedge aclk);
        while (!stat_ready && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        check("cmd_ready_timeout", stat_ready, 1'b1);
        ctrl_valid = 1'b1;
        ctrl_addr = a;
        ctrl_len = l;
        ctrl_ctl = c;
        acc_edge = cyc + 1;
        acc_beats = beats_seen;
        beats = int'(l >> 5);
        nb = (beats + BL - 1) / BL;
        rem = beats % BL;
        for (int i = 0; i < beats; i++) begin
            beat_t b;
            b.d = mem_data(a + 64'(i) * 64'd32);
            b.last = (i == beats - 1);
            b.done = c && b.last;
            exp_beat_q.push_back(b);
        end
        for (int k = 0; k < nb; k++) begin
            ar_t r;
            r.a = a + 64'(k) * 64'd512;
            r.len = (k == nb - 1 && rem != 0) ? 8'(rem - 1) : 8'd15;
            exp_ar_q.push_back(r);
        end
        @(negedge aclk);
        ctrl_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        #2;
        while (!idle() && n < 3000) begin
            @(negedge aclk);
            #2;
            n++;
        end
        check(tag, idle(), 1'b1);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge aclk);
        #2;
    endtask

    initial begin
        int b_ar, b_tl, b_dn, b_bt, n;

        repeat (3) @(negedge aclk);
        #2;
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_stat_ready", stat_ready, 1'b1);
        check("rst_stat_done", stat_done, 1'b0);
        reset = 1'b0;
        wait_cycles(2);

        // Single burst
        b_ar = ar_seen; b_tl = tlast_seen; b_dn = done_seen; b_bt = beats_seen;
        send_cmd(64'h1000, 32'd512, 1'b1);
        wait_idle("single_idle");
        check("single_ars", ar_seen - b_ar, 1);
        check("single_beats", beats_seen - b_bt, 16);
        check("single_tlast", tlast_seen - b_tl, 1);
        check("single_done", done_seen - b_dn, 1);
        check("ar_latency", arv_rise_edge, acc_edge + 1);

        // Partial tail
        b_ar = ar_seen; b_tl = tlast_seen; b_bt = beats_seen;
        send_cmd(64'h1000, 32'd1056, 1'b1);
        wait_idle("tail_idle");
        check("tail_ars", ar_seen - b_ar, 3);
        check("tail_beats", beats_seen - b_bt, 33);
        check("tail_tlast", tlast_seen - b_tl, 1);
        check("tail_ready_rise", rdy_rise_edge, last_ar_edge);

        // Outstanding cap with R withheld
        b_ar = ar_seen; b_tl = tlast_seen;
        r_limit = r_started;
        send_cmd(64'h8000, 32'd4096, 1'b0);
        wait_cycles(30);
        check("cap_two_ars", ar_seen - b_ar, 2);
        r_limit = r_started + 1;
        wait_cycles(40);
        check("cap_one_more", ar_seen - b_ar, 3);
        r_limit = 1000000;
        wait_idle("cap_idle");
        check("cap_total_ars", ar_seen - b_ar, 8);
        check("cap_tlast", tlast_seen - b_tl, 1);

        // Random stream backpressure
        b_tl = tlast_seen; b_bt = beats_seen;
        bp = 1'b1;
        send_cmd(64'h20000, 32'd2048, 1'b1);
        wait_idle("bp_idle");
        bp = 1'b0;
        check("bp_beats", beats_seen - b_bt, 64);
        check("bp_tlast", tlast_seen - b_tl, 1);

        // Back-to-back commands
        b_tl = tlast_seen; b_dn = done_seen; b_bt = beats_seen;
        send_cmd(64'h30000, 32'd512, 1'b0);
        send_cmd(64'h31000, 32'd512, 1'b1);
        check("b2b_overlap", (acc_beats - b_bt) < 16, 1'b1);
        wait_idle("b2b_idle");
        check("b2b_tlast", tlast_seen - b_tl, 2);
        check("b2b_done", done_seen - b_dn, 1);

        // Zero length
        b_ar = ar_seen; b_dn = done_seen;
        send_cmd(64'h40000, 32'd0, 1'b1);
        wait_cycles(6);
        check("zero_ready_rise", rdy_rise_edge, acc_edge + 1);
        check("zero_ars", ar_seen - b_ar, 0);
        check("zero_done", done_seen - b_dn, 0);

        // Reset during the third burst
        b_bt = beats_seen;
        send_cmd(64'h50000, 32'd4096, 1'b1);
        n = 0;
        while ((beats_seen - b_bt) < 40 && n < 3000) begin
            @(negedge aclk);
            #2;
            n++;
        end
        check("mid_reached_burst3", (beats_seen - b_bt) >= 40, 1'b1);
        reset = 1'b1;
        @(negedge aclk);
        #2;
        check("mid_rst_arvalid", arvalid, 1'b0);
        check("mid_rst_stat_ready", stat_ready, 1'b1);
        reset = 1'b0;
        wait_cycles(2);
        b_tl = tlast_seen; b_dn = done_seen; b_bt = beats_seen;
        send_cmd(64'h60000, 32'd512, 1'b1);
        wait_idle("post_rst_idle");
        check("post_rst_beats", beats_seen - b_bt, 16);
        check("post_rst_tlast", tlast_seen - b_tl, 1);
        check("post_rst_done", done_seen - b_dn, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
